// File: rtl/cache_assoc_pkg.sv
// cache_assoc_pkg: shared FSM encoding, bus direction constants and
// the tag-width helper for the 2-way set-associative cache.
package cache_assoc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RESP = 2'd2,
        WSYS = 2'd3
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Byte address is {tag, index, offset, 2'b00}.
    function automatic int tag_width(input int idx_w, input int ofs_w);
        return 30 - idx_w - ofs_w;
    endfunction

endpackage

// File: rtl/cache_way.sv
// cache_way: one way of the cache -- tag, valid and line storage plus
// the hit compare for the addressed set.
// Ports: clock/reset (sync, clears valid bits only); idx/ofs/tag select
// and compare; hit/valid/rdata report the lookup; wr_en/wr_ofs/wr_data
// write one word of set idx; fill_done writes the tag and sets valid.
module cache_way
    import cache_assoc_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int OFS_W = 4,
    parameter int TAG_W = tag_width(6, 4)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] idx,
    input  logic [OFS_W-1:0] ofs,
    input  logic [TAG_W-1:0] tag,
    output logic             hit,
    output logic             valid,
    output logic [31:0]      rdata,
    input  logic             wr_en,
    input  logic [OFS_W-1:0] wr_ofs,
    input  logic [31:0]      wr_data,
    input  logic             fill_done
);

    localparam int SETS  = 1 << IDX_W;
    localparam int WORDS = 1 << (IDX_W + OFS_W);

    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [WORDS];
    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  valid_d;

    always_comb begin
        valid_d = valid_q;
        if (fill_done) begin
            valid_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data storage are deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (fill_done) begin
            tag_q[idx] <= tag;
        end
        if (wr_en) begin
            data_q[{idx, wr_ofs}] <= wr_data;
        end
    end

    assign valid = valid_q[idx];
    assign hit   = valid_q[idx] && (tag_q[idx] == tag);
    assign rdata = data_q[{idx, ofs}];

endmodule

// File: rtl/cache_assoc.sv
// cache_assoc: 2-way set-associative, write-through, no-write-allocate
// cache with LRU replacement; optional stats via CACHE_STATS_EN.
// Ports: clock, reset (sync, active-high); processor side PStrobe, PRw,
// PAddress, PData_out -> PData_in, CReady; system side SysStrobe, SysRW,
// SysAddress, SysData_in -> SysData_out, SysReady; with CACHE_STATS_EN
// also hit_count and miss_count.
module cache_assoc
    import cache_assoc_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int OFS_W = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PStrobe,
    input  logic        PRw,
    input  logic [31:0] PAddress,
    input  logic [31:0] PData_out,
    output logic [31:0] PData_in,
    output logic        CReady,
    output logic        SysStrobe,
    output logic        SysRW,
    output logic [31:0] SysAddress,
    output logic [31:0] SysData_in,
    input  logic [31:0] SysData_out,
    input  logic        SysReady
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int TAG_W = tag_width(IDX_W, OFS_W);
    localparam int SETS  = 1 << IDX_W;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] idx;
    logic [OFS_W-1:0] ofs;
    logic             unused_lsb;

    assign req_tag    = PAddress[31 -: TAG_W];
    assign idx        = PAddress[OFS_W+2 +: IDX_W];
    assign ofs        = PAddress[2 +: OFS_W];
    assign unused_lsb = ^PAddress[1:0];

    state_t           state_q, state_d;
    logic [OFS_W-1:0] word_cnt_q, word_cnt_d;
    logic             victim_q, victim_d;
    logic [SETS-1:0]  lru_q, lru_d;
    logic [31:0]      pdata_q, pdata_d;
    logic             cready_q, cready_d;

    logic [1:0]       hit;
    logic [1:0]       valid;
    logic [31:0]      rdata [2];
    logic [1:0]       way_we;
    logic [1:0]       way_fill;
    logic [OFS_W-1:0] wr_ofs;
    logic [31:0]      wr_data;

    logic             sys_strobe;
    logic             sys_rw;
    logic [31:0]      sys_addr;
    logic [31:0]      sys_wdata;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
`endif

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way #(
            .IDX_W(IDX_W),
            .OFS_W(OFS_W),
            .TAG_W(TAG_W)
        ) u_way (
            .clock    (clock),
            .reset    (reset),
            .idx      (idx),
            .ofs      (ofs),
            .tag      (req_tag),
            .hit      (hit[w]),
            .valid    (valid[w]),
            .rdata    (rdata[w]),
            .wr_en    (way_we[w] & ~reset),
            .wr_ofs   (wr_ofs),
            .wr_data  (wr_data),
            .fill_done(way_fill[w] & ~reset)
        );
    end

    // lru bit of a set names the way to evict next.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        victim_d   = victim_q;
        lru_d      = lru_q;
        pdata_d    = pdata_q;
        cready_d   = 1'b0;
        way_we     = '0;
        way_fill   = '0;
        wr_ofs     = ofs;
        wr_data    = PData_out;
        sys_strobe = 1'b0;
        sys_rw     = RW_READ;
        sys_addr   = '0;
        sys_wdata  = '0;
`ifdef CACHE_STATS_EN
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (PStrobe) begin
                    if (PRw == RW_READ) begin
                        if (|hit) begin
                            pdata_d    = hit[0] ? rdata[0] : rdata[1];
                            cready_d   = 1'b1;
                            lru_d[idx] = hit[0];
`ifdef CACHE_STATS_EN
                            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
`endif
                        end else begin
                            victim_d   = !valid[0] ? 1'b0 :
                                         !valid[1] ? 1'b1 : lru_q[idx];
                            word_cnt_d = '0;
                            state_d    = FILL;
                        end
                    end else begin
                        if (|hit) begin
                            way_we     = hit;
                            lru_d[idx] = hit[0];
                        end
                        state_d = WSYS;
                    end
                end
            end
            FILL: begin
                sys_strobe = 1'b1;
                sys_addr   = {req_tag, idx, word_cnt_q, 2'b00};
                if (SysReady) begin
                    way_we[victim_q] = 1'b1;
                    wr_ofs           = word_cnt_q;
                    wr_data          = SysData_out;
                    word_cnt_d       = word_cnt_q + 1'b1;
                    if (&word_cnt_q) begin
                        way_fill[victim_q] = 1'b1;
                        lru_d[idx]         = ~victim_q;
                        state_d            = RESP;
                    end
                end
            end
            RESP: begin
                pdata_d  = rdata[victim_q];
                cready_d = 1'b1;
                state_d  = IDLE;
`ifdef CACHE_STATS_EN
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
`endif
            end
            WSYS: begin
                sys_strobe = 1'b1;
                sys_rw     = RW_WRITE;
                sys_addr   = {PAddress[31:2], 2'b00};
                sys_wdata  = PData_out;
                if (SysReady) begin
                    cready_d = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            victim_q   <= 1'b0;
            lru_q      <= '0;
            pdata_q    <= '0;
            cready_q   <= 1'b0;
`ifdef CACHE_STATS_EN
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            victim_q   <= victim_d;
            lru_q      <= lru_d;
            pdata_q    <= pdata_d;
            cready_q   <= cready_d;
`ifdef CACHE_STATS_EN
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
`endif
        end
    end

    // Outputs are forced quiet while reset is held, not just after it.
    assign CReady     = cready_q & ~reset;
    assign PData_in   = reset ? '0 : pdata_q;
    assign SysStrobe  = sys_strobe & ~reset;
    assign SysRW      = sys_rw | reset;
    assign SysAddress = reset ? '0 : sys_addr;
    assign SysData_in = reset ? '0 : sys_wdata;

`ifdef CACHE_STATS_EN
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_assoc.sv
// tb_cache_assoc: directed self-checking bench for cache_assoc.
// Memory returns SysAddress + 0x1000_0000 for every read word.
module tb_cache_assoc;

    logic        clock;
    logic        reset;
    logic        PStrobe;
    logic        PRw;
    logic [31:0] PAddress;
    logic [31:0] PData_out;
    logic [31:0] PData_in;
    logic        CReady;
    logic        SysStrobe;
    logic        SysRW;
    logic [31:0] SysAddress;
    logic [31:0] SysData_in;
    logic [31:0] SysData_out;
    logic        SysReady;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int vec  = 0;
    int miss = 0;

    cache_assoc dut (
        .clock      (clock),
        .reset      (reset),
        .PStrobe    (PStrobe),
        .PRw        (PRw),
        .PAddress   (PAddress),
        .PData_out  (PData_out),
        .PData_in   (PData_in),
        .CReady     (CReady),
        .SysStrobe  (SysStrobe),
        .SysRW      (SysRW),
        .SysAddress (SysAddress),
        .SysData_in (SysData_in),
        .SysData_out(SysData_out),
        .SysReady   (SysReady)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign SysData_out = SysAddress + 32'h1000_0000;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec++;
        assert (got === exp) else begin
            miss++;
            $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Issue one request and follow it until CReady (or abort via reset
    // at the rst_at-th acknowledge). lat counts edges from the request
    // edge (inclusive) to the edge that raises CReady.
    task automatic do_req(input bit now, input logic rw,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int rst_at, output int lat, output int acks,
                          output logic [31:0] rdata, output bit bus_ok);
        logic [31:0] exp_a;
        bit          done;
        if (!now) @(negedge clock);
        PStrobe   = 1'b1;
        PRw       = rw;
        PAddress  = addr;
        PData_out = wdata;
        lat    = 0;
        acks   = 0;
        rdata  = '0;
        bus_ok = 1'b1;
        done   = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (SysStrobe && SysReady) begin
                exp_a = rw ? {addr[31:6], acks[3:0], 2'b00} : addr;
                if (SysAddress !== exp_a || SysRW !== rw ||
                    (!rw && SysData_in !== wdata)) bus_ok = 1'b0;
                acks++;
            end else if (!SysStrobe &&
                         (SysAddress !== '0 || SysData_in !== '0)) begin
                bus_ok = 1'b0;
            end
            if (rst_at != 0 && acks == rst_at) begin
                reset = 1'b1;
                #1;
                chk("rst_mid_cready", {31'd0, CReady}, 32'd0);
                chk("rst_mid_strobe", {31'd0, SysStrobe}, 32'd0);
                chk("rst_mid_rw", {31'd0, SysRW}, 32'd1);
                chk("rst_mid_pdata", PData_in, 32'd0);
                @(posedge clock);
                #1;
                reset   = 1'b0;
                PStrobe = 1'b0;
                done    = 1'b1;
            end else begin
                @(posedge clock);
                lat++;
                #1 PStrobe = 1'b0;
                @(negedge clock);
                if (CReady) begin
                    rdata = PData_in;
                    done  = 1'b1;
                end
            end
        end
    endtask

    int          lat;
    int          acks;
    logic [31:0] rd;
    bit          ok;
    int          cr_seen;

    initial begin
        reset     = 1'b1;
        PStrobe   = 1'b0;
        PRw       = 1'b1;
        PAddress  = '0;
        PData_out = '0;
        SysReady  = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_cready", {31'd0, CReady}, 32'd0);
        chk("reset_sysstrobe", {31'd0, SysStrobe}, 32'd0);
        chk("reset_sysrw", {31'd0, SysRW}, 32'd1);
        chk("reset_pdata", PData_in, 32'd0);
        reset = 1'b0;

        // Cold miss: 16 acks, CReady 18 edges after request.
        do_req(0, 1'b1, 32'h0000_1040, '0, 0, lat, acks, rd, ok);
        chk("miss1040_lat", lat, 32'd18);
        chk("miss1040_acks", acks, 32'd16);
        chk("miss1040_data", rd, 32'h1000_1040);
        chk("miss1040_bus", {31'd0, ok}, 32'd1);

        // Hit on word 1 of the same line.
        do_req(0, 1'b1, 32'h0000_1044, '0, 0, lat, acks, rd, ok);
        chk("hit1044_lat", lat, 32'd1);
        chk("hit1044_acks", acks, 32'd0);
        chk("hit1044_data", rd, 32'h1000_1044);
`ifdef CACHE_STATS_EN
        chk("stats_hit", hit_count, 32'd1);
        chk("stats_miss", miss_count, 32'd1);
`endif

        // Second line in set 1 goes to way 1.
        do_req(0, 1'b1, 32'h0000_2040, '0, 0, lat, acks, rd, ok);
        chk("miss2040_acks", acks, 32'd16);
        chk("miss2040_data", rd, 32'h1000_2040);

        // Back-to-back: issued in the CReady cycle; way 1 becomes LRU.
        do_req(1, 1'b1, 32'h0000_1040, '0, 0, lat, acks, rd, ok);
        chk("b2b_hit1040_lat", lat, 32'd1);
        chk("b2b_hit1040_data", rd, 32'h1000_1040);

        // Third tag in set 1 evicts 0x2040 (way 1).
        do_req(0, 1'b1, 32'h0000_3040, '0, 0, lat, acks, rd, ok);
        chk("miss3040_acks", acks, 32'd16);
        chk("miss3040_data", rd, 32'h1000_3040);
        chk("miss3040_bus", {31'd0, ok}, 32'd1);

        do_req(0, 1'b1, 32'h0000_107C, '0, 0, lat, acks, rd, ok);
        chk("hit107c_lat", lat, 32'd1);
        chk("hit107c_data", rd, 32'h1000_107C);

        do_req(0, 1'b1, 32'h0000_2040, '0, 0, lat, acks, rd, ok);
        chk("evicted2040_acks", acks, 32'd16);

        // Write hit: write-through, local word updated.
        do_req(0, 1'b0, 32'h0000_1048, 32'hDEAD_BEEF, 0, lat, acks, rd, ok);
        chk("wr1048_lat", lat, 32'd2);
        chk("wr1048_acks", acks, 32'd1);
        chk("wr1048_bus", {31'd0, ok}, 32'd1);

        do_req(1, 1'b1, 32'h0000_1048, '0, 0, lat, acks, rd, ok);
        chk("rd1048_lat", lat, 32'd1);
        chk("rd1048_data", rd, 32'hDEAD_BEEF);

        // Write miss: no allocate.
        do_req(0, 1'b0, 32'h0000_5000, 32'h1234_5678, 0, lat, acks, rd, ok);
        chk("wr5000_acks", acks, 32'd1);
        chk("wr5000_bus", {31'd0, ok}, 32'd1);

        do_req(0, 1'b1, 32'h0000_5000, '0, 0, lat, acks, rd, ok);
        chk("rd5000_acks", acks, 32'd16);
        chk("rd5000_data", rd, 32'h1000_5000);

        // Reset at the 5th acknowledge of a fill.
        do_req(0, 1'b1, 32'h0000_7080, '0, 5, lat, acks, rd, ok);
        cr_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (CReady || SysStrobe) cr_seen++;
        end
        chk("abort_quiet", cr_seen, 32'd0);

        do_req(0, 1'b1, 32'h0000_7080, '0, 0, lat, acks, rd, ok);
        chk("refill7080_lat", lat, 32'd18);
        chk("refill7080_acks", acks, 32'd16);
        chk("refill7080_data", rd, 32'h1000_7080);
        chk("refill7080_bus", {31'd0, ok}, 32'd1);

        // Reset cleared every valid bit.
        do_req(0, 1'b1, 32'h0000_1040, '0, 0, lat, acks, rd, ok);
        chk("post_rst_1040_acks", acks, 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/cache_assoc.md
CACHE_ASSOC -- requirements
Module: cache_assoc

Interface
REQ-001 SHALL have parameter IDX_W, default 6, meaning set index width (2^IDX_W sets).
REQ-002 SHALL have parameter OFS_W, default 4, meaning word-offset width (2^OFS_W 32-bit words per line).
REQ-003 SHALL derive TAG_W = 30 - IDX_W - OFS_W; address = {tag, index, offset, 2'b00}.
REQ-004 SHALL have port clock, input, 1: one clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-006 SHALL have port PStrobe, input, 1: processor request pulse.
REQ-007 SHALL have port PRw, input, 1: 1 = read, 0 = write.
REQ-008 SHALL have port PAddress, input, 32: byte address; bits 1:0 are ignored.
REQ-009 SHALL have port PData_out, input, 32: processor write data.
REQ-010 SHALL have port PData_in, output, 32: read data to the processor.
REQ-011 SHALL have port CReady, output, 1: one-cycle request-complete pulse.
REQ-012 SHALL have ports SysStrobe (output, 1), SysRW (output, 1), SysAddress (output, 32), SysData_in (output, 32), SysData_out (input, 32), SysReady (input, 1): system-bus request, direction, address, write data, read data, per-word acknowledge.

Function
REQ-013 SHALL be 2-way set-associative; each way holds a tag, a valid bit and a data line per set; each set holds one LRU bit.
REQ-014 SHALL hold PAddress, PRw and PData_out stable from PStrobe until CReady; the cache SHALL ignore PStrobe while busy.
REQ-015 SHALL use an FSM with states IDLE, FILL, RESP and WSYS.
REQ-016 Read hit (IDLE, PStrobe, PRw=1, valid and tag match in either way): PData_in is registered and CReady is pulsed at T+1; LRU points to the other way; the FSM stays in IDLE.
REQ-017 Read miss: victim = invalid way (way 0 before way 1), otherwise the LRU way; the FSM enters FILL.
REQ-018 FILL: SysStrobe=1, SysRW=1, SysAddress = {tag, index, word_cnt, 2'b00}; on each SysReady, SysData_out is written to victim[word_cnt] and word_cnt increments, starting at 0 and wrapping at 2^OFS_W.
REQ-019 On the last-word SysReady: tag is written, valid is set, LRU is updated and the FSM enters RESP; SysStrobe is 0 from the next cycle.
REQ-020 RESP: PData_in = requested word, CReady is pulsed, and the FSM returns to IDLE. Total miss latency = 2^OFS_W SysReady events + 2 cycles.
REQ-021 Write (PRw=0) is write-through, no-write-allocate.
  - On a hit, the word in the hit way is updated and LRU is updated.
  - On a miss, cache contents are unchanged.
  - In both cases the FSM enters WSYS.
REQ-022 WSYS: SysStrobe=1, SysRW=0, SysAddress=PAddress, SysData_in=PData_out; on SysReady the FSM pulses CReady next cycle and returns to IDLE.
REQ-023 SysData_in SHALL be 0 and SysAddress SHALL be 0 when SysStrobe=0.
REQ-024 PStrobe on the same cycle as the CReady pulse SHALL be accepted as a new request.
REQ-025 SysReady while SysStrobe=0 SHALL be ignored.

Reset
REQ-026 reset SHALL clear every valid bit, every LRU bit, word_cnt and the FSM (to IDLE) in one cycle; tag and data RAM contents are not reset.
REQ-027 During reset: CReady=0, SysStrobe=0, SysRW=1, PData_in=0.
REQ-028 reset during FILL or WSYS SHALL abort the transaction with no CReady; a partially filled line SHALL remain invalid.

Configuration
REQ-029 With CACHE_STATS_EN defined:
  - 32-bit outputs hit_count and miss_count SHALL exist, cleared by reset.
  - Each counts one per completed read hit or read miss, saturating at 0xFFFFFFFF.
REQ-030 Without CACHE_STATS_EN: those ports and counters SHALL be absent, with no other behaviour change.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the RW_READ/RW_WRITE constants and a function deriving TAG_W.
REQ-032 One sub-module, cache_way (tag, valid and data storage plus hit compare for one way), SHALL be instantiated twice.

Verification
REQ-033 After reset, read 0x0000_1040 with SysReady every cycle -> SysAddress steps 0x1040..0x107C, CReady after 16 acks + 2, PData_in = word 0.
REQ-034 Repeat the read of 0x0000_1044 -> no SysStrobe, CReady at T+1, PData_in = word 1 of the fill.
REQ-035 Fill 0x1040, then 0x2040, then read 0x1040 (hit), then read 0x3040 -> the 0x2040 line (way 1, LRU) is evicted, and a subsequent 0x1040 read still hits.
REQ-036 Write 0xDEADBEEF to 0x1048 (hit) -> SysRW=0 with SysData_in=0xDEADBEEF; a following read of 0x1048 hits with 0xDEADBEEF. Write to a missing address 0x5000 -> a later read of 0x5000 misses.
REQ-037 Assert reset at the 5th SysReady of a fill -> no CReady; a re-read of the same address misses and refetches all 16 words.
REQ-038 With CACHE_STATS_EN defined, scenario REQ-033 followed by REQ-034 -> hit_count=1, miss_count=1.
